div_unit: RTL and testbench



---
 rtl/div_unit_if.sv | 27 ++
 rtl/div_unit.sv | 111 +++++++++++
 tb/tb_div_unit.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// Start/done handshake and operand/result bus between the control unit and div_unit.
// The div_unsigned select exists only when DIV_UNSIGNED_EN is defined.
interface div_unit_if;
  logic        div_start;
  logic [31:0] dividend;
  logic [31:0] divisor;
`ifdef DIV_UNSIGNED_EN
  logic        div_unsigned;
`endif
  logic [31:0] lo;
  logic [31:0] hi;
  logic        div_busy;
  logic        div_done;
  logic        div_zero;

`ifdef DIV_UNSIGNED_EN
  modport master (output div_start, dividend, divisor, div_unsigned,
                  input  lo, hi, div_busy, div_done, div_zero);
  modport slave  (input  div_start, dividend, divisor, div_unsigned,
                  output lo, hi, div_busy, div_done, div_zero);
`else
  modport master (output div_start, dividend, divisor,
                  input  lo, hi, div_busy, div_done, div_zero);
  modport slave  (input  div_start, dividend, divisor,
                  output lo, hi, div_busy, div_done, div_zero);
`endif
endinterface

// File: rtl/div_unit.sv
// Multicycle 32-bit restoring divider (DIV, plus DIVU when DIV_UNSIGNED_EN is defined).
// One quotient bit per cycle; quotient to lo, remainder to hi, both registered.
module div_unit (
  input logic       clk,
  input logic       reset,
  div_unit_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]  state;
  logic [4:0]  count;
  logic [31:0] prem;
  logic [31:0] shreg;
  logic [31:0] mag_b;
  logic        neg_q;
  logic        neg_r;
  logic [31:0] lo_r;
  logic [31:0] hi_r;
  logic        busy_r;
  logic        done_r;
  logic        zero_r;

  logic        unsigned_op;
  logic        sa;
  logic        sb;
  logic [31:0] mag_a_in;
  logic [31:0] mag_b_in;
  logic [32:0] trial;
  logic [32:0] diff;
  logic        ge;

`ifdef DIV_UNSIGNED_EN
  assign unsigned_op = bus.div_unsigned;
`else
  assign unsigned_op = 1'b0;
`endif

  // 0x80000000 negates to itself, which is already the correct unsigned magnitude.
  always_comb begin
    sa       = ~unsigned_op & bus.dividend[31];
    sb       = ~unsigned_op & bus.divisor[31];
    mag_a_in = sa ? (32'd0 - bus.dividend) : bus.dividend;
    mag_b_in = sb ? (32'd0 - bus.divisor)  : bus.divisor;
    trial    = {prem, shreg[31]};
    diff     = trial - {1'b0, mag_b};
    ge       = ~diff[32];
  end

  // shreg starts as |A| and fills with quotient bits from the bottom as dividend bits leave the top.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      count  <= '0;
      prem   <= '0;
      shreg  <= '0;
      mag_b  <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      lo_r   <= '0;
      hi_r   <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      zero_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      zero_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.div_start) begin
            if (bus.divisor == '0) begin
              zero_r <= 1'b1;
            end else begin
              shreg  <= mag_a_in;
              mag_b  <= mag_b_in;
              neg_q  <= sa ^ sb;
              neg_r  <= sa;
              prem   <= '0;
              count  <= '0;
              busy_r <= 1'b1;
              state  <= S_RUN;
            end
          end
        end
        S_RUN: begin
          prem  <= ge ? diff[31:0] : trial[31:0];
          shreg <= {shreg[30:0], ge};
          count <= count + 5'd1;
          if (count == 5'd31) state <= S_FIX;
        end
        S_FIX: begin
          lo_r   <= neg_q ? (32'd0 - shreg) : shreg;
          hi_r   <= neg_r ? (32'd0 - prem)  : prem;
          done_r <= 1'b1;
          busy_r <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.lo       = lo_r;
  assign bus.hi       = hi_r;
  assign bus.div_busy = busy_r;
  assign bus.div_done = done_r;
  assign bus.div_zero = zero_r;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vectors plus random operands against an arithmetic model.
// Build with DIV_UNSIGNED_EN defined to also exercise the unsigned path.
module tb_div_unit;

  logic clk;
  logic reset;
  int   checks;
  int   passed;

  div_unit_if bus ();

  div_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog expired");
  end

  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic uns,
                                output logic [31:0] q, output logic [31:0] r);
    longint sa;
    longint sb;
    longint lq;
    longint lr;
    if (uns) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      lq = sa / sb;
      lr = sa % sb;
      q  = lq[31:0];
      r  = lr[31:0];
    end
  endfunction

  function automatic logic [31:0] rand_op(input bit nonzero);
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0:       v = 32'($urandom_range(0, 20));
      1:       v = 32'd0 - 32'($urandom_range(1, 20));
      2:       v = 32'h8000_0000;
      3:       v = 32'hFFFF_FFFF;
      default: v = $urandom;
    endcase
    if (nonzero && v == 32'd0) v = 32'd1;
    return v;
  endfunction

  task automatic set_uns(input logic uns);
`ifdef DIV_UNSIGNED_EN
    bus.div_unsigned = uns;
`else
    if (uns) $display("note: unsigned request ignored in signed-only build");
`endif
  endtask

  // Starts one division and waits for div_done; operands are scrambled (and with noise, start
  // is pulsed) during the run to show they are latched and that starts are ignored while busy.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic uns, input bit noise,
                         output int lat, output bit flow_ok, output logic [31:0] q, output logic [31:0] r);
    bus.div_start = 1'b1;
    bus.dividend  = a;
    bus.divisor   = b;
    set_uns(uns);
    @(posedge clk); #1;
    bus.div_start = 1'b0;
    lat     = -1;
    flow_ok = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      bus.dividend = $urandom;
      bus.divisor  = (($urandom_range(0, 3) == 0) ? 32'd0 : $urandom);
      if (noise) begin
        bus.div_start = 1'($urandom_range(0, 1));
`ifdef DIV_UNSIGNED_EN
        bus.div_unsigned = 1'($urandom_range(0, 1));
`endif
      end
      @(posedge clk); #1;
      if (bus.div_done) begin
        lat = e;
        break;
      end
      if (!bus.div_busy || bus.div_zero) flow_ok = 1'b0;
    end
    bus.div_start = 1'b0;
    q = bus.lo;
    r = bus.hi;
  endtask

  task automatic test_reset;
    reset         = 1'b0;
    bus.div_start = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    set_uns(1'b0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.lo, bus.hi, bus.div_busy, bus.div_done, bus.div_zero} !== 67'd0)
      $display("FAIL reset_outputs: got lo=%h hi=%h busy=%b done=%b zero=%b expected all zero",
               bus.lo, bus.hi, bus.div_busy, bus.div_done, bus.div_zero);
    else passed++;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    logic [31:0] va [4] = '{32'd100, 32'hFFFF_FFF9, 32'd7,          32'h8000_0000};
    logic [31:0] vb [4] = '{32'd7,   32'd2,         32'hFFFF_FFFE,  32'hFFFF_FFFF};
    logic [31:0] eq [4] = '{32'd14,  32'hFFFF_FFFD, 32'hFFFF_FFFD,  32'h8000_0000};
    logic [31:0] er [4] = '{32'd2,   32'hFFFF_FFFF, 32'd1,          32'd0};
    int          lat;
    bit          ok;
    logic [31:0] q;
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      run_div(va[i], vb[i], 1'b0, 1'b0, lat, ok, q, r);
      checks++;
      if (lat !== 33) $display("FAIL dir%0d_latency: got %0d expected 33", i, lat); else passed++;
      checks++;
      if (!ok) $display("FAIL dir%0d_flow: got busy/zero glitch expected busy=1 zero=0 during run", i); else passed++;
      checks++;
      if (q !== eq[i]) $display("FAIL dir%0d_lo: got %h expected %h", i, q, eq[i]); else passed++;
      checks++;
      if (r !== er[i]) $display("FAIL dir%0d_hi: got %h expected %h", i, r, er[i]); else passed++;
      checks++;
      if (bus.div_busy !== 1'b0) $display("FAIL dir%0d_busy_at_done: got %b expected 0", i, bus.div_busy); else passed++;
      @(posedge clk); #1;
      checks++;
      if (bus.div_done !== 1'b0) $display("FAIL dir%0d_done_width: got %b expected 0", i, bus.div_done); else passed++;
    end
  endtask

  task automatic test_div_zero;
    int          lat;
    bit          ok;
    logic [31:0] q;
    logic [31:0] r;
    run_div(32'd100, 32'd7, 1'b0, 1'b0, lat, ok, q, r);
    @(posedge clk); #1;
    bus.div_start = 1'b1;
    bus.dividend  = 32'd5;
    bus.divisor   = 32'd0;
    @(posedge clk); #1;
    bus.div_start = 1'b0;
    checks++;
    if (bus.div_zero !== 1'b1) $display("FAIL zero_pulse: got %b expected 1", bus.div_zero); else passed++;
    checks++;
    if (bus.div_done !== 1'b0) $display("FAIL zero_done: got %b expected 0", bus.div_done); else passed++;
    checks++;
    if (bus.div_busy !== 1'b0) $display("FAIL zero_busy: got %b expected 0", bus.div_busy); else passed++;
    checks++;
    if ({bus.lo, bus.hi} !== {32'd14, 32'd2}) $display("FAIL zero_hold: got lo=%h hi=%h expected lo=0000000e hi=00000002", bus.lo, bus.hi); else passed++;
    @(posedge clk); #1;
    checks++;
    if ({bus.div_zero, bus.div_done, bus.div_busy} !== 3'b000)
      $display("FAIL zero_width: got zero=%b done=%b busy=%b expected 000", bus.div_zero, bus.div_done, bus.div_busy);
    else passed++;
  endtask

  task automatic test_random;
    int          lat;
    bit          ok;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic [31:0] eq;
    logic [31:0] er;
    for (int i = 0; i < 12; i++) begin
      a = rand_op(1'b0);
      b = rand_op(1'b1);
      model(a, b, 1'b0, eq, er);
      run_div(a, b, 1'b0, 1'b0, lat, ok, q, r);
      checks++;
      if (lat !== 33 || !ok) $display("FAIL rand%0d_timing: got lat=%0d flow=%b expected lat=33 flow=1", i, lat, ok); else passed++;
      checks++;
      if ({q, r} !== {eq, er}) $display("FAIL rand%0d_result %h/%h: got lo=%h hi=%h expected lo=%h hi=%h", i, a, b, q, r, eq, er); else passed++;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
  endtask

  // Each start is issued on the cycle div_done is visible, i.e. accepted at the earliest edge.
  task automatic test_back_to_back;
    int          lat;
    bit          ok;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic [31:0] eq;
    logic [31:0] er;
    for (int i = 0; i < 10; i++) begin
      a = rand_op(1'b0);
      b = rand_op(1'b1);
      model(a, b, 1'b0, eq, er);
      run_div(a, b, 1'b0, 1'b1, lat, ok, q, r);
      checks++;
      if (lat !== 33 || !ok) $display("FAIL b2b%0d_timing: got lat=%0d flow=%b expected lat=33 flow=1", i, lat, ok); else passed++;
      checks++;
      if ({q, r} !== {eq, er}) $display("FAIL b2b%0d_result %h/%h: got lo=%h hi=%h expected lo=%h hi=%h", i, a, b, q, r, eq, er); else passed++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort;
    bit          saw_done;
    int          lat;
    bit          ok;
    logic [31:0] q;
    logic [31:0] r;
    saw_done      = 1'b0;
    bus.div_start = 1'b1;
    bus.dividend  = 32'd100;
    bus.divisor   = 32'd7;
    set_uns(1'b0);
    @(posedge clk); #1;
    bus.div_start = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      if (e == 10) begin
        bus.div_start = 1'b1;
        bus.dividend  = 32'd9;
        bus.divisor   = 32'd3;
      end
      @(posedge clk); #1;
      bus.div_start = 1'b0;
      if (bus.div_done) saw_done = 1'b1;
    end
    checks++;
    if (bus.div_busy !== 1'b1 || saw_done) $display("FAIL abort_running: got busy=%b done_seen=%b expected busy=1 done_seen=0", bus.div_busy, saw_done); else passed++;
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.lo, bus.hi, bus.div_busy, bus.div_done, bus.div_zero} !== 67'd0)
      $display("FAIL abort_async: got lo=%h hi=%h busy=%b done=%b zero=%b expected all zero",
               bus.lo, bus.hi, bus.div_busy, bus.div_done, bus.div_zero);
    else passed++;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int e = 0; e < 40; e++) begin
      @(posedge clk); #1;
      if (bus.div_done || bus.div_busy) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) $display("FAIL abort_no_done: got activity after reset expected idle"); else passed++;
    run_div(32'd9, 32'd3, 1'b0, 1'b0, lat, ok, q, r);
    checks++;
    if (lat !== 33 || {q, r} !== {32'd3, 32'd0}) $display("FAIL abort_recover: got lat=%0d lo=%h hi=%h expected lat=33 lo=00000003 hi=00000000", lat, q, r); else passed++;
    @(posedge clk); #1;
  endtask

`ifdef DIV_UNSIGNED_EN
  task automatic test_unsigned;
    int          lat;
    bit          ok;
    logic [31:0] a;
    logic [31:0] b;
    logic        u;
    logic [31:0] q;
    logic [31:0] r;
    logic [31:0] eq;
    logic [31:0] er;
    run_div(32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0, lat, ok, q, r);
    checks++;
    if (lat !== 33 || {q, r} !== {32'h7FFF_FFFF, 32'd1}) $display("FAIL divu_dir: got lat=%0d lo=%h hi=%h expected lat=33 lo=7fffffff hi=00000001", lat, q, r); else passed++;
    run_div(32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, lat, ok, q, r);
    checks++;
    if (lat !== 33 || {q, r} !== {32'd0, 32'hFFFF_FFFF}) $display("FAIL div_same_ops: got lat=%0d lo=%h hi=%h expected lat=33 lo=00000000 hi=ffffffff", lat, q, r); else passed++;
    for (int i = 0; i < 8; i++) begin
      a = rand_op(1'b0);
      b = rand_op(1'b1);
      u = 1'($urandom_range(0, 1));
      model(a, b, u, eq, er);
      run_div(a, b, u, 1'b1, lat, ok, q, r);
      checks++;
      if (lat !== 33 || !ok || {q, r} !== {eq, er})
        $display("FAIL mix%0d u=%b %h/%h: got lat=%0d lo=%h hi=%h expected lat=33 lo=%h hi=%h", i, u, a, b, lat, q, r, eq, er);
      else passed++;
    end
    set_uns(1'b0);
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    checks = 0;
    passed = 0;
    test_reset;
    test_directed;
    test_div_zero;
    test_random;
    test_back_to_back;
    test_reset_abort;
`ifdef DIV_UNSIGNED_EN
    test_unsigned;
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
